// File: rtl/trap_unit.sv
// -----------------------------------------------------------------------------
// trap_unit
//   Trap entry / mret sequencer for a single-hart machine-mode core. A
//   trap or return request from writeback is accepted in IDLE. The next
//   cycle (COMMIT) pulses the CSR write strobe with the new mstatus, mepc,
//   mcause and mtval values. The cycle after that (REDIRECT) presents the new
//   fetch PC until fetch takes it. The pipeline flush stays asserted from the
//   cycle after acceptance until the redirect handshake completes.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid / req_ready   writeback request handshake (ready only in IDLE)
//   req_excep               trap/return request (enable, mret, mcause, mepc, mtval)
//   csr_mtvec, csr_mepc     current CSR values
//   csr_mstatus             current mstatus
//   csr_we                  one-cycle CSR write strobe
//   epc_we                  qualifies the mepc_o/mcause_o/mtval_o writes (trap only)
//   mstatus_o, mepc_o,
//   mcause_o, mtval_o       new CSR values
//   priv_mode               current privilege mode
//   flush                   pipeline flush request
//   redirect_valid/_pc/_ready  fetch redirect handshake
//
// Build option
//   TRAP_VECTORED_EN  when defined, asynchronous interrupts (mcause[63]=1)
//                     with mtvec.MODE=01 jump to base + 4*cause; otherwise
//                     every trap jumps to the mtvec base.
// -----------------------------------------------------------------------------
package trap_unit_pkg;
  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_M = 2'b11;

  // Standard RV64 mstatus layout; only mie, mpie and mpp are touched here.
  typedef struct packed {
    logic [50:0] upper;   // [63:13] SD, XS, FS, ... passed through unchanged
    logic [1:0]  mpp;     // [12:11]
    logic [1:0]  vs;      // [10:9]
    logic        spp;     // [8]
    logic        mpie;    // [7]
    logic        ube;     // [6]
    logic        spie;    // [5]
    logic        wpri_4;  // [4]
    logic        mie;     // [3]
    logic        wpri_2;  // [2]
    logic        sie;     // [1]
    logic        wpri_0;  // [0]
  } mstatus_t;

  typedef struct packed {
    logic        enable;
    logic        mret;
    logic [63:0] mcause;
    logic [63:0] mepc;
    logic [63:0] mtval;
  } excep_data_t;
endpackage

module trap_unit
  import trap_unit_pkg::*;
#(
  parameter logic [1:0] RESET_MODE = MODE_M
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  excep_data_t req_excep,
  input  logic [63:0] csr_mtvec,
  input  logic [63:0] csr_mepc,
  input  mstatus_t    csr_mstatus,
  output logic        csr_we,
  output logic        epc_we,
  output mstatus_t    mstatus_o,
  output logic [63:0] mepc_o,
  output logic [63:0] mcause_o,
  output logic [63:0] mtval_o,
  output logic [1:0]  priv_mode,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COMMIT   = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        trap_q, trap_d;          // latched request is a trap (not mret)
  logic [1:0]  priv_tgt_q, priv_tgt_d;  // privilege mode taken in COMMIT
  logic [1:0]  priv_mode_q, priv_mode_d;
  logic        ready_q, ready_d;
  logic        csr_we_q, csr_we_d;
  logic        epc_we_q, epc_we_d;
  mstatus_t    mstatus_q, mstatus_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mtval_q, mtval_d;
  logic        flush_q, flush_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rpc_q, rpc_d;

  logic        accept_s;
  logic [63:0] tvec_base_s;
  logic [63:0] trap_pc_s;

  // mstatus after trap entry: stack mie into mpie, disable, remember mode.
  function automatic mstatus_t trap_entry_mstatus(input mstatus_t old_ms,
                                                  input logic [1:0] old_priv);
    mstatus_t ms;
    ms      = old_ms;
    ms.mpie = old_ms.mie;
    ms.mie  = 1'b0;
    ms.mpp  = old_priv;
    return ms;
  endfunction

  // mstatus after mret: restore mie from mpie, re-arm mpie, drop mpp to U.
  function automatic mstatus_t mret_mstatus(input mstatus_t old_ms);
    mstatus_t ms;
    ms      = old_ms;
    ms.mie  = old_ms.mpie;
    ms.mpie = 1'b1;
    ms.mpp  = MODE_U;
    return ms;
  endfunction

  assign accept_s = (state_q == ST_IDLE) && req_valid &&
                    (req_excep.enable || req_excep.mret);

  // Trap target from the live mtvec; mcause_q holds the accepted trap's cause.
  always_comb begin
    tvec_base_s = csr_mtvec & ~64'd3;
`ifdef TRAP_VECTORED_EN
    if ((csr_mtvec[1:0] == 2'b01) && mcause_q[63]) begin
      // 4*mcause[62:0] truncated to 64 bits
      trap_pc_s = tvec_base_s + {mcause_q[61:0], 2'b00};
    end else begin
      trap_pc_s = tvec_base_s;
    end
`else
    trap_pc_s = tvec_base_s;
`endif
  end

  // Next-state and next-output logic of the IDLE/COMMIT/REDIRECT sequencer.
  always_comb begin
    state_d     = state_q;
    trap_d      = trap_q;
    priv_tgt_d  = priv_tgt_q;
    priv_mode_d = priv_mode_q;
    csr_we_d    = 1'b0;  // strobe: high only for the COMMIT cycle
    epc_we_d    = 1'b0;
    mstatus_d   = mstatus_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    mtval_d     = mtval_q;
    flush_d     = flush_q;
    rvalid_d    = rvalid_q;
    rpc_d       = rpc_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_COMMIT;
          csr_we_d = 1'b1;
          flush_d  = 1'b1;
          // enable wins over mret when both are set
          if (req_excep.enable) begin
            trap_d     = 1'b1;
            epc_we_d   = 1'b1;
            priv_tgt_d = MODE_M;
            mstatus_d  = trap_entry_mstatus(csr_mstatus, priv_mode_q);
            mepc_d     = req_excep.mepc;
            mcause_d   = req_excep.mcause;
            mtval_d    = req_excep.mtval;
          end else begin
            trap_d     = 1'b0;
            priv_tgt_d = csr_mstatus.mpp;
            mstatus_d  = mret_mstatus(csr_mstatus);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        state_d     = ST_REDIRECT;
        priv_mode_d = priv_tgt_q;
        rvalid_d    = 1'b1;
        rpc_d       = trap_q ? trap_pc_s : csr_mepc;
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
          flush_d  = 1'b0;
        end else begin
          state_d  = ST_REDIRECT;
          rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        flush_d  = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset abandons any request in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      trap_q      <= 1'b0;
      priv_tgt_q  <= RESET_MODE;
      priv_mode_q <= RESET_MODE;
      ready_q     <= 1'b1;
      csr_we_q    <= 1'b0;
      epc_we_q    <= 1'b0;
      mstatus_q   <= mstatus_t'(64'd0);
      mepc_q      <= 64'd0;
      mcause_q    <= 64'd0;
      mtval_q     <= 64'd0;
      flush_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rpc_q       <= 64'd0;
    end else begin
      state_q     <= state_d;
      trap_q      <= trap_d;
      priv_tgt_q  <= priv_tgt_d;
      priv_mode_q <= priv_mode_d;
      ready_q     <= ready_d;
      csr_we_q    <= csr_we_d;
      epc_we_q    <= epc_we_d;
      mstatus_q   <= mstatus_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      mtval_q     <= mtval_d;
      flush_q     <= flush_d;
      rvalid_q    <= rvalid_d;
      rpc_q       <= rpc_d;
    end
  end

  assign req_ready      = ready_q;
  assign csr_we         = csr_we_q;
  assign epc_we         = epc_we_q;
  assign mstatus_o      = mstatus_q;
  assign mepc_o         = mepc_q;
  assign mcause_o       = mcause_q;
  assign mtval_o        = mtval_q;
  assign priv_mode      = priv_mode_q;
  assign flush          = flush_q;
  assign redirect_valid = rvalid_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_trap_unit.sv
// Testbench for trap_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level
// reference model.
module tb_trap_unit;
  import trap_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  excep_data_t req_excep;
  logic [63:0] csr_mtvec;
  logic [63:0] csr_mepc;
  mstatus_t    csr_mstatus;
  logic        csr_we;
  logic        epc_we;
  mstatus_t    mstatus_o;
  logic [63:0] mepc_o;
  logic [63:0] mcause_o;
  logic [63:0] mtval_o;
  logic [1:0]  priv_mode;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;

  int n_checks = 0;
  int n_pass   = 0;

  trap_unit #(.RESET_MODE(2'b11)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_excep(req_excep), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_mstatus(csr_mstatus), .csr_we(csr_we), .epc_we(epc_we),
    .mstatus_o(mstatus_o), .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o),
    .priv_mode(priv_mode), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
  endtask

  // ---------------- input snapshot at each rising edge ----------------
  logic        s_rst, s_valid, s_en, s_mret, s_rready;
  logic [63:0] s_cause, s_epc, s_tval, s_mtvec, s_mepc, s_ms;
  always @(posedge clk) begin
    s_rst    <= reset_n;
    s_valid  <= req_valid;
    s_en     <= req_excep.enable;
    s_mret   <= req_excep.mret;
    s_cause  <= req_excep.mcause;
    s_epc    <= req_excep.mepc;
    s_tval   <= req_excep.mtval;
    s_mtvec  <= csr_mtvec;
    s_mepc   <= csr_mepc;
    s_ms     <= csr_mstatus;
    s_rready <= redirect_ready;
  end

  // ---------------- reference model ----------------
  // Transaction view: a request is "in flight" from acceptance until the
  // redirect is taken; age counts cycles since acceptance.
  bit          m_busy, m_trap, m_cwe, m_ewe, m_rv;
  int          m_age;
  logic [1:0]  m_priv, m_pend;
  logic [63:0] m_ms, m_epc, m_cause, m_tval, m_pc;

  function automatic logic [63:0] ref_target(input logic [63:0] tvec, input logic [63:0] cause);
    logic [63:0] base;
    base = tvec - (tvec % 64'd4);
`ifdef TRAP_VECTORED_EN
    if ((tvec % 64'd4) == 64'd1 && cause[63] == 1'b1)
      return base + 64'd4 * (cause & 64'h7FFF_FFFF_FFFF_FFFF);
`endif
    return base;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_trap = 0; m_cwe = 0; m_ewe = 0; m_rv = 0; m_age = 0;
    m_priv = 2'b11; m_pend = 2'b11;
    m_ms = 64'd0; m_epc = 64'd0; m_cause = 64'd0; m_tval = 64'd0; m_pc = 64'd0;
  endtask

  task automatic model_step();
    m_cwe = 0;
    m_ewe = 0;
    if (!m_busy) begin
      if (s_valid && (s_en || s_mret)) begin
        m_busy = 1; m_age = 1; m_cwe = 1;
        m_trap = s_en;
        m_ms   = s_ms;
        if (s_en) begin
          m_ewe = 1;
          m_ms[7] = s_ms[3];
          m_ms[3] = 1'b0;
          m_ms[12:11] = m_priv;
          m_pend = 2'b11;
          m_epc = s_epc; m_cause = s_cause; m_tval = s_tval;
        end else begin
          m_ms[3] = s_ms[7];
          m_ms[7] = 1'b1;
          m_ms[12:11] = 2'b00;
          m_pend = s_ms[12:11];
        end
      end
    end else if (m_age == 1) begin
      m_age  = 2;
      m_priv = m_pend;
      m_rv   = 1;
      m_pc   = m_trap ? ref_target(s_mtvec, m_cause) : s_mepc;
    end else begin
      m_age++;
      if (s_rready) begin
        m_busy = 0;
        m_rv   = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("req_ready", 64'(req_ready), 64'(!m_busy));
    chk("csr_we", 64'(csr_we), 64'(m_cwe));
    chk("epc_we", 64'(epc_we), 64'(m_ewe));
    chk("flush", 64'(flush), 64'(m_busy));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
    chk("redirect_pc", redirect_pc, m_pc);
    chk("priv_mode", 64'(priv_mode), 64'(m_priv));
    chk("mstatus_o", mstatus_o, m_ms);
    chk("mepc_o", mepc_o, m_epc);
    chk("mcause_o", mcause_o, m_cause);
    chk("mtval_o", mtval_o, m_tval);
  endtask

  // Model/compare process: advance once per rising edge, compare mid-cycle.
  initial begin
    model_reset();
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      if (!reset_n || !s_rst) model_reset();
      else model_step();
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic en, input logic mr, input logic [63:0] cause,
                      input logic [63:0] epc, input logic [63:0] tval);
    req_valid        = 1'b1;
    req_excep.enable = en;
    req_excep.mret   = mr;
    req_excep.mcause = cause;
    req_excep.mepc   = epc;
    req_excep.mtval  = tval;
  endtask

  initial begin
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_excep      = '0;
    csr_mtvec      = 64'd0;
    csr_mepc       = 64'd0;
    csr_mstatus    = mstatus_t'(64'd0);
    redirect_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_priv", 64'(priv_mode), 64'd3);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_rvalid", 64'(redirect_valid), 64'd0);
    chk("rst_csr_we", 64'(csr_we), 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    chk("rst_mstatus", mstatus_o, 64'd0);
    chk("model_vec_pin", ref_target(64'h8000_0001, 64'h8000_0000_0000_0007),
`ifdef TRAP_VECTORED_EN
        64'h8000_001C);
`else
        64'h8000_0000);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // mret back to U-mode
    csr_mstatus = mstatus_t'(64'h80);
    csr_mepc    = 64'h8000_0104;
    send(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mret_csr_we", 64'(csr_we), 64'd1);
    chk("mret_epc_we", 64'(epc_we), 64'd0);
    chk("mret_mstatus", mstatus_o, 64'h88);
    @(negedge clk);
    chk("mret_rvalid", 64'(redirect_valid), 64'd1);
    chk("mret_pc", redirect_pc, 64'h8000_0104);
    chk("mret_priv", 64'(priv_mode), 64'd0);
    @(negedge clk);
    chk("mret_done_flush", 64'(flush), 64'd0);

    // ecall from U-mode
    csr_mstatus = mstatus_t'(64'h1808);
    csr_mtvec   = 64'h8000_0000;
    send(1'b1, 1'b0, 64'd8, 64'h8000_0100, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ecall_csr_we", 64'(csr_we), 64'd1);
    chk("ecall_epc_we", 64'(epc_we), 64'd1);
    chk("ecall_mstatus", mstatus_o, 64'h80);
    chk("ecall_mcause", mcause_o, 64'd8);
    chk("ecall_mepc", mepc_o, 64'h8000_0100);
    @(negedge clk);
    chk("ecall_priv", 64'(priv_mode), 64'd3);
    chk("ecall_rvalid", 64'(redirect_valid), 64'd1);
    chk("ecall_pc", redirect_pc, 64'h8000_0000);
    @(negedge clk);

    // Redirect back-pressure; a second request is ignored meanwhile
    redirect_ready = 1'b0;
    csr_mtvec      = 64'h8000_0203;
    send(1'b1, 1'b0, 64'd2, 64'h8000_0200, 64'h55);
    @(negedge clk);
    send(1'b1, 1'b0, 64'd11, 64'h9000_0000, 64'h66);
    @(negedge clk);
    chk("bp_pc0", redirect_pc, 64'h8000_0200);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rvalid", 64'(redirect_valid), 64'd1);
      chk("bp_flush", 64'(flush), 64'd1);
      chk("bp_pc", redirect_pc, 64'h8000_0200);
      chk("bp_csr_we", 64'(csr_we), 64'd0);
    end
    redirect_ready = 1'b1;
    req_valid      = 1'b0;
    @(negedge clk);
    chk("bp_idle_rvalid", 64'(redirect_valid), 64'd0);
    chk("bp_idle_flush", 64'(flush), 64'd0);
    chk("bp_idle_ready", 64'(req_ready), 64'd1);
    chk("bp_mcause_kept", mcause_o, 64'd2);

    // enable and mret together act as a trap
    csr_mstatus = mstatus_t'(64'd0);
    csr_mtvec   = 64'h8000_0041;
    send(1'b1, 1'b1, 64'd3, 64'h8000_0300, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("both_epc_we", 64'(epc_we), 64'd1);
    @(negedge clk);
    chk("both_pc", redirect_pc, 64'h8000_0040);
    @(negedge clk);

    // mret to U, then reset during COMMIT of the next trap
    csr_mstatus = mstatus_t'(64'd0);
    send(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_priv", 64'(priv_mode), 64'd0);
    send(1'b1, 1'b0, 64'd2, 64'h8000_0400, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_csr_we_pre", 64'(csr_we), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_flush", 64'(flush), 64'd0);
    chk("mid_rvalid", 64'(redirect_valid), 64'd0);
    chk("mid_priv", 64'(priv_mode), 64'd3);
    chk("mid_csr_we", 64'(csr_we), 64'd0);
    @(posedge clk);
    #1 chk("mid_csr_we_edge", 64'(csr_we), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_ready", 64'(req_ready), 64'd1);
    chk("mid_no_redirect", 64'(redirect_valid), 64'd0);

    // Vectored interrupt target
    csr_mtvec = 64'h8000_0001;
    send(1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h8000_0500, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
`ifdef TRAP_VECTORED_EN
    chk("vec_pc", redirect_pc, 64'h8000_001C);
`else
    chk("vec_pc", redirect_pc, 64'h8000_0000);
`endif
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid        = ($urandom_range(0, 1) == 1);
      req_excep.enable = 1'($urandom_range(0, 1));
      req_excep.mret   = 1'($urandom_range(0, 1));
      req_excep.mcause = {1'($urandom_range(0, 1)), 58'd0, 5'($urandom_range(0, 31))};
      req_excep.mepc   = {$urandom, $urandom};
      req_excep.mtval  = {$urandom, $urandom};
      csr_mtvec        = {$urandom, $urandom};
      csr_mepc         = {$urandom, $urandom};
      csr_mstatus      = mstatus_t'({$urandom, $urandom});
      redirect_ready   = ($urandom_range(0, 2) != 0);
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 SHALL have parameter RESET_MODE, default 2'b11 (MODE_M), meaning privilege mode loaded at reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, the writeback stage presents a trap or return request.
REQ-005 SHALL have port req_ready, output, 1, the unit accepts the request this cycle.
REQ-006 SHALL have port req_excep, input, excep_data_t, with fields enable, mret, mcause, mepc and mtval used.
REQ-007 SHALL have ports csr_mtvec, csr_mepc, input, 64 each, the current CSR values.
REQ-008 SHALL have port csr_mstatus, input, mstatus_t, the current mstatus.
REQ-009 SHALL have port csr_we, output, 1, one-cycle strobe to write the mstatus_o, mepc_o, mcause_o and mtval_o outputs into the CSR file.
REQ-010 SHALL have port epc_we, output, 1, strobe qualifying the mepc_o, mcause_o and mtval_o writes (trap entry only).
REQ-011 SHALL have ports mstatus_o (mstatus_t), mepc_o (64), mcause_o (64) and mtval_o (64), all outputs, carrying the new CSR values.
REQ-012 SHALL have port priv_mode, output, 2, the current privilege mode register.
REQ-013 SHALL have port flush, output, 1, pipeline flush request.
REQ-014 SHALL have ports redirect_valid (output, 1), redirect_pc (output, 64) and redirect_ready (input, 1), the fetch redirect handshake.

Function
REQ-015 SHALL implement FSM states IDLE, COMMIT and REDIRECT.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready && (enable || mret), else it is ignored.
REQ-017 SHALL register the request on acceptance, assert flush from the cycle after acceptance until the redirect handshake completes, and transition IDLE->COMMIT.
REQ-018 SHALL, in COMMIT, pulse csr_we for exactly one cycle, update priv_mode, and transition to REDIRECT.
REQ-019 SHALL, on trap entry (enable=1) in COMMIT: mstatus_o.mpie=old mie, mie=0, mpp=old priv_mode, other fields unchanged; epc_we=1; mepc_o/mcause_o/mtval_o taken from the request; priv_mode set to MODE_M.
REQ-020 SHALL, on mret in COMMIT: mie=old mpie, mpie=1, mpp=MODE_U; priv_mode=old mpp; epc_we=0.
REQ-021 SHALL give enable priority over mret when both are set; the request is treated as a trap.
REQ-022 SHALL compute redirect_pc in COMMIT and hold it stable while redirect_valid=1: trap target is {csr_mtvec[63:2],2'b00}; mret target is csr_mepc.
REQ-023 SHALL hold redirect_valid=1 in REDIRECT until redirect_ready=1, then return to IDLE the next cycle with flush=0.
REQ-024 SHALL have a request-to-redirect latency of 2 cycles: accept at N, csr_we at N+1, redirect_valid at N+2; the minimum spacing between accepts is 3 cycles.
REQ-025 SHALL ignore req_valid during COMMIT and REDIRECT with no loss of the latched request.

Reset
REQ-026 SHALL, while reset_n=0 (asynchronously), set the state to IDLE, priv_mode=RESET_MODE, csr_we=epc_we=flush=redirect_valid=0, redirect_pc=0, and all CSR outputs to 0.
REQ-027 SHALL abandon any trap in progress on reset mid-operation, issue no csr_we, and resume in IDLE after reset_n rises.

Configuration
REQ-028 SHALL, with TRAP_VECTORED_EN defined, use redirect_pc={mtvec[63:2],2'b00}+4*mcause[62:0] when mtvec[1:0]==2'b01 and mcause[63]==1, and the base otherwise.
REQ-029 SHALL, without TRAP_VECTORED_EN, always use the base address regardless of mtvec[1:0].

Verification
REQ-030 SHALL verify ecall from U-mode (mcause=8, mepc=0x8000_0100, mtvec=0x8000_0000, mie=1): csr_we at N+1; mpie=1, mie=0, mpp=00; priv_mode=11; redirect_pc=0x8000_0000 at N+2.
REQ-031 SHALL verify mret with mpp=00, mpie=1 and csr_mepc=0x8000_0104: mie=1, mpie=1, mpp=00; priv_mode=00; redirect_pc=0x8000_0104.
REQ-032 SHALL verify that with redirect_ready held 0 for 5 cycles, redirect_valid and flush stay 1 and redirect_pc is stable; a second req_valid is ignored; return to IDLE one cycle after ready=1.
REQ-033 SHALL verify that enable=1 and mret=1 together behave as a trap (epc_we=1 and target = mtvec base).
REQ-034 SHALL verify that reset_n dropped in COMMIT immediately clears flush and redirect_valid, sets priv_mode=11, and produces no csr_we pulse.
REQ-035 SHALL verify with TRAP_VECTORED_EN, mtvec=0x8000_0001 and mcause=0x8000_0000_0000_0007 that redirect_pc=0x8000_001C; without the macro, redirect_pc=0x8000_0000.
